// File: rtl/camera_pixel_filter_if.sv
// Bus interfaces for camera_pixel_filter.
//   cam_pix_if  : camera pixel stream (10-bit R/G/B + one-cycle valid strobe).
//                 master = camera data controller, slave = filter.
//   sdram_wr_if : packed SDRAM write word, write strobe and the pixel
//                 coordinates/frame-done tag travelling with it.
//                 master = filter, slave = SDRAM write port.
interface cam_pix_if;
  logic [9:0] iRed;
  logic [9:0] iGreen;
  logic [9:0] iBlue;
  logic       iValid;
  modport master (output iRed, iGreen, iBlue, iValid);
  modport slave  (input  iRed, iGreen, iBlue, iValid);
endinterface

interface sdram_wr_if;
  logic [15:0] oWR_Data_1;   // {1'b0, G[9:5], B[9:0]}
  logic [15:0] oWR_Data_2;   // {1'b0, G[4:0], R[9:0]}
  logic        oWR_En;
  logic [9:0]  oPixel_X;
  logic [8:0]  oLine_Y;
  logic        oFrame_Done;
  modport master (output oWR_Data_1, oWR_Data_2, oWR_En, oPixel_X, oLine_Y, oFrame_Done);
  modport slave  (input  oWR_Data_1, oWR_Data_2, oWR_En, oPixel_X, oLine_Y, oFrame_Done);
endinterface

// File: rtl/camera_pixel_filter.sv
// camera_pixel_filter: per-frame pixel conversion between the camera stream
// and the SDRAM write port. Modes: 0 passthrough, 1 grayscale, 2 horizontal
// edge magnitude, 3 thresholded edge. One output word per input pixel.
// Ports:
//   Clock, Resetn     clock, async active-low reset
//   Enable            sync run enable; low returns to IDLE and clears counters
//   iFrame_Start      frame start pulse; loads mode/threshold shadows
//   iMode, iThreshold per-frame mode and edge threshold
//   pix (slave)       camera pixel stream
//   wr  (master)      packed SDRAM write word + coordinates + frame done
//   oOverrun          sticky: iValid seen on two consecutive cycles
module camera_pixel_filter #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  input  logic        iFrame_Start,
  input  logic [1:0]  iMode,
  input  logic [9:0]  iThreshold,
  cam_pix_if.slave    pix,
  sdram_wr_if.master  wr,
  output logic        oOverrun
);

  localparam logic [9:0] XL = 10'(IMG_WIDTH - 1);
  localparam logic [8:0] YL = 9'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state, st_eff, nxt;

  logic [1:0]  mode_q;
  logic [9:0]  thr_q;
  logic [9:0]  in_x, x_eff;
  logic [8:0]  in_y, y_eff;
  logic        vld_d;

  // Held pixel (cur) and luma of its left neighbour (prev_y)
  logic [9:0]  cur_r, cur_g, cur_b, cur_y, prev_y;
  logic [9:0]  cur_x;
  logic [8:0]  cur_ln;

  logic [11:0] sum;
  logic [9:0]  y_new, right_y, edge_v;
  logic [9:0]  o_r, o_g, o_b;
  logic        accept, emit;

  logic [15:0] d1_q, d2_q;
  logic [9:0]  px_q;
  logic [8:0]  ln_q;
  logic        en_q, fd_q, ovr_q;

  // A frame start in the same cycle acts before the pixel: the state and
  // counters seen by this cycle's pixel are already the fresh-frame values.
  always_comb begin
    st_eff = state;
    x_eff  = in_x;
    y_eff  = in_y;
    if (iFrame_Start) begin
      st_eff = IDLE;
      x_eff  = '0;
      y_eff  = '0;
    end
  end

  assign sum   = {2'b00, pix.iRed} + {1'b0, pix.iGreen, 1'b0} + {2'b00, pix.iBlue};
  assign y_new = sum[11:2];

  assign accept = Enable && pix.iValid && (st_eff == IDLE || st_eff == RUN);
  assign emit   = Enable && ((st_eff == RUN && pix.iValid) || st_eff == FLUSH);

  // In FLUSH there is no right neighbour: the last pixel replicates itself.
  assign right_y = (st_eff == FLUSH) ? cur_y : y_new;
  assign edge_v  = (right_y >= prev_y) ? (right_y - prev_y) : (prev_y - right_y);

  always_comb begin
    o_r = cur_r;
    o_g = cur_g;
    o_b = cur_b;
    case (mode_q)
      2'd1: begin o_r = cur_y;  o_g = cur_y;  o_b = cur_y;  end
      2'd2: begin o_r = edge_v; o_g = edge_v; o_b = edge_v; end
      2'd3: begin
        o_r = (edge_v >= thr_q) ? 10'h3FF : 10'h000;
        o_g = o_r;
        o_b = o_r;
      end
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    nxt = st_eff;
    case (st_eff)
      IDLE:  if (accept) nxt = (x_eff == XL) ? FLUSH : RUN;
      RUN:   if (accept) nxt = (x_eff == XL) ? FLUSH : RUN;
      FLUSH: nxt = (cur_ln == YL) ? DONE : IDLE;
      DONE:  nxt = DONE;
      default: nxt = IDLE;
    endcase
    if (!Enable) nxt = IDLE;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= nxt;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      mode_q <= '0; thr_q <= '0;
      in_x <= '0; in_y <= '0; vld_d <= 1'b0;
      cur_r <= '0; cur_g <= '0; cur_b <= '0; cur_y <= '0; prev_y <= '0;
      cur_x <= '0; cur_ln <= '0;
      d1_q <= '0; d2_q <= '0; px_q <= '0; ln_q <= '0;
      en_q <= 1'b0; fd_q <= 1'b0; ovr_q <= 1'b0;
    end else begin
      en_q <= 1'b0;
      fd_q <= 1'b0;
      if (!Enable) begin
        in_x  <= '0;
        in_y  <= '0;
        vld_d <= 1'b0;
      end else begin
        vld_d <= pix.iValid;
        if (iFrame_Start) begin
          mode_q <= iMode;
          thr_q  <= iThreshold;
          ovr_q  <= 1'b0;
        end else if (pix.iValid && vld_d) begin
          ovr_q  <= 1'b1;
        end
        in_x <= x_eff;
        in_y <= y_eff;
        // Output for the held pixel; coordinates come along with it.
        if (emit) begin
          en_q <= 1'b1;
          d1_q <= {1'b0, o_g[9:5], o_b};
          d2_q <= {1'b0, o_g[4:0], o_r};
          px_q <= cur_x;
          ln_q <= cur_ln;
          fd_q <= (cur_x == XL) && (cur_ln == YL);
        end
        if (accept) begin
          prev_y <= (st_eff == IDLE) ? y_new : cur_y;
          cur_r  <= pix.iRed;
          cur_g  <= pix.iGreen;
          cur_b  <= pix.iBlue;
          cur_y  <= y_new;
          cur_x  <= x_eff;
          cur_ln <= y_eff;
          if (x_eff == XL) begin
            in_x <= '0;
            in_y <= y_eff + 9'd1;
          end else begin
            in_x <= x_eff + 10'd1;
          end
        end
      end
    end
  end

  assign wr.oWR_Data_1  = d1_q;
  assign wr.oWR_Data_2  = d2_q;
  assign wr.oWR_En      = en_q;
  assign wr.oPixel_X    = px_q;
  assign wr.oLine_Y     = ln_q;
  assign wr.oFrame_Done = fd_q;
  assign oOverrun       = ovr_q;

endmodule
